// File: rtl/wiredng_cache_sram.sv
// wiredng_cache_sram: per-bank tag/data SRAM responder with 1-cycle reads,
// refill write port and a self-clearing tag-invalidate engine.
package wiredng_cache_sram_pkg;
    localparam int PA_LENGTH = 48;
    localparam int WAY_COUNT = 4;
    localparam int SET_COUNT = 1024;

    typedef struct packed {
        logic                  valid;
        logic [PA_LENGTH-1:14] tag;
    } cache_tag_t;
endpackage

module wiredng_cache_sram
    import wiredng_cache_sram_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [13:4]                     sram_addr_i,
    output logic [WAY_COUNT-1:0][63:0]      data_o,
    output cache_tag_t [WAY_COUNT-1:0]      stag_o,
    input  logic                            wr_valid_i,
    output logic                            wr_ready_o,
    input  logic [13:4]                     wr_index_i,
    input  logic [WAY_COUNT-1:0]            wr_way_i,
    input  logic                            wr_data_en_i,
    input  logic [63:0]                     wr_data_i,
    input  logic                            wr_tag_en_i,
    input  cache_tag_t                      wr_tag_i,
    input  logic                            flush_i,
    output logic                            busy_o
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e                         state_q;
    state_e                         state_d;
    logic [9:0]                     clr_cnt_q;
    logic [9:0]                     clr_cnt_d;
    logic                           clr_we;
    logic                           clearing;
    logic                           wr_fire;

    logic [63:0]                    data_mem [WAY_COUNT][SET_COUNT];
    cache_tag_t                     tag_mem  [WAY_COUNT][SET_COUNT];

    logic [WAY_COUNT-1:0][63:0]     data_q;
    logic [WAY_COUNT-1:0][63:0]     data_d;
    cache_tag_t [WAY_COUNT-1:0]     stag_q;
    cache_tag_t [WAY_COUNT-1:0]     stag_d;

    // State register and clear counter; reset restarts the full clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: sweep all sets in CLEAR, re-enter CLEAR on flush from RUN.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 10'd1;
                if (clr_cnt_q == 10'd1023) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (flush_i) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = S_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // FSM outputs; rst also holds off writes before the state register resets.
    always_comb begin
        clearing = 1'b0;
        unique case (state_q)
            S_CLEAR: clearing = 1'b1;
            S_RUN:   clearing = 1'b0;
            default: clearing = 1'b1;
        endcase
        clr_we     = clearing;
        busy_o     = clearing | rst;
        wr_ready_o = ~busy_o;
    end

    assign wr_fire = wr_valid_i & wr_ready_o;

    // Data array: refill writes only; never cleared.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAY_COUNT; w++) begin
            if (wr_fire && wr_way_i[w] && wr_data_en_i) begin
                data_mem[w][wr_index_i] <= wr_data_i;
            end
        end
    end

    // Tag array: invalidate sweep has priority; refill writes only in RUN.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAY_COUNT; w++) begin
            if (clr_we) begin
                tag_mem[w][clr_cnt_q] <= '0;
            end else if (wr_fire && wr_way_i[w] && wr_tag_en_i) begin
                tag_mem[w][wr_index_i] <= wr_tag_i;
            end
        end
    end

    // Read mux: array contents with write-first forwarding, zeros while clearing.
    always_comb begin
        data_d = '0;
        stag_d = '0;
        for (int w = 0; w < WAY_COUNT; w++) begin
            data_d[w] = data_mem[w][sram_addr_i];
            stag_d[w] = tag_mem[w][sram_addr_i];
            if (wr_fire && wr_way_i[w] && (wr_index_i == sram_addr_i)) begin
                if (wr_data_en_i) begin
                    data_d[w] = wr_data_i;
                end
                if (wr_tag_en_i) begin
                    stag_d[w] = wr_tag_i;
                end
            end
        end
        if (clearing) begin
            data_d = '0;
            stag_d = '0;
        end
    end

    // Output register: one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            stag_q <= '0;
        end else begin
            data_q <= data_d;
            stag_q <= stag_d;
        end
    end

    assign data_o = data_q;
    assign stag_o = stag_q;

endmodule
